// File: rtl/fifo_param.sv
// Single-clock synchronous FIFO with registered read data, occupancy count,
// threshold-based almost-full/almost-empty flags and a sticky error flag.
module fifo_param #(
  parameter int DATA_BITS = 10,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 push,
  input  logic                 pop,
  input  logic [ADDR_BITS:0]   thr_high,
  input  logic [ADDR_BITS:0]   thr_low,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic [ADDR_BITS:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 fifo_error
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS + 1)'(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic                 wr_ok;
  logic                 rd_ok;
  logic                 reject;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= thr_high);
  assign almost_empty = (count <= thr_low);

  // Acceptance is judged on the count at the start of the cycle, so a pop
  // on a full FIFO never frees room for a same-cycle push (and vice versa).
  assign wr_ok  = push & ~full;
  assign rd_ok  = pop & ~empty;
  assign reject = (push & full) | (pop & empty);

  // Storage is deliberately left unreset; writes are blocked during reset.
  always_ff @(posedge clk) begin
    if (reset_L && wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      fifo_error <= 1'b0;
    end else begin
      valid_out <= rd_ok;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (wr_ok && !rd_ok) begin
        count <= count + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count <= count - 1'b1;
      end
      if (reject) begin
        fifo_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param: stimulus queues expected read words,
// an independent monitor checks every valid_out beat against the queue.
module tb_fifo_param;

  logic       clk = 1'b0;
  logic       reset_L;
  logic [9:0] data_in;
  logic       push;
  logic       pop;
  logic [3:0] thr_high;
  logic [3:0] thr_low;
  logic [9:0] data_out;
  logic       valid_out;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       fifo_error;

  int total  = 0;
  int passed = 0;
  logic [9:0] exp_q[$];

  fifo_param #(.DATA_BITS(10), .ADDR_BITS(3)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .data_in      (data_in),
    .push         (push),
    .pop          (pop),
    .thr_high     (thr_high),
    .thr_low      (thr_low),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_error   (fifo_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Drive one cycle; returns 2 time units after the edge with outputs settled.
  task automatic cyc(input logic p, input logic q, input logic [9:0] d);
    push = p;
    pop = q;
    data_in = d;
    @(posedge clk);
    #2;
    push = 1'b0;
    pop = 1'b0;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    cyc(1'b0, 1'b0, 10'h0);
    reset_L = 1'b1;
  endtask

  task automatic pop_exp(input logic [9:0] e);
    exp_q.push_back(e);
    cyc(1'b0, 1'b1, 10'h0);
  endtask

  // Monitor: every valid_out beat must match the oldest queued expectation.
  initial begin
    logic [9:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (reset_L && valid_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("data_out", int'(data_out), int'(e));
        end
      end
    end
  end

  initial begin
    reset_L = 1'b1;
    push = 1'b0;
    pop = 1'b0;
    data_in = '0;
    thr_high = 4'd6;
    thr_low = 4'd1;
    @(posedge clk);
    #2;

    // Reset then idle
    do_reset();
    cyc(1'b0, 1'b0, 10'h0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_almost_empty", int'(almost_empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_almost_full", int'(almost_full), 0);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_valid_out", int'(valid_out), 0);
    chk("rst_fifo_error", int'(fifo_error), 0);

    // Fill 0x001..0x008 then drain
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 10'(i));
      chk("fill_count", int'(count), i);
      chk("fill_almost_full", int'(almost_full), (i >= 6) ? 1 : 0);
      chk("fill_almost_empty", int'(almost_empty), (i <= 1) ? 1 : 0);
    end
    chk("fill_full", int'(full), 1);
    for (int i = 1; i <= 8; i++) pop_exp(10'(i));
    chk("drain_empty", int'(empty), 1);
    chk("drain_count", int'(count), 0);
    chk("drain_error", int'(fifo_error), 0);

    // Overflow: push while full
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 10'(i));
    thr_high = 4'd15;
    #1;
    chk("thr_above_depth_af", int'(almost_full), 0);
    thr_high = 4'd6;
    cyc(1'b1, 1'b0, 10'h0AA);
    chk("ovf_count", int'(count), 8);
    chk("ovf_error", int'(fifo_error), 1);
    pop_exp(10'h001);
    chk("ovf_error_sticky", int'(fifo_error), 1);
    chk("ovf_pop_count", int'(count), 7);

    // Full with push and pop together: pop wins, push rejected
    cyc(1'b1, 1'b0, 10'h009);
    exp_q.push_back(10'h002);
    cyc(1'b1, 1'b1, 10'h0BB);
    chk("full_pp_count", int'(count), 7);

    // Steady state at count 4 across pointer wrap
    do_reset();
    chk("rst2_error", int'(fifo_error), 0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 10'h021 + 10'(i));
    for (int i = 0; i < 20; i++) begin
      if (i < 4) exp_q.push_back(10'h021 + 10'(i));
      else exp_q.push_back(10'h100 + 10'(i - 4));
      cyc(1'b1, 1'b1, 10'h100 + 10'(i));
      chk("pp_count", int'(count), 4);
    end
    chk("pp_error", int'(fifo_error), 0);
    for (int i = 16; i < 20; i++) pop_exp(10'h100 + 10'(i));
    chk("pp_drain_empty", int'(empty), 1);

    // Empty with push and pop together: push wins, pop rejected
    cyc(1'b1, 1'b1, 10'h3FF);
    chk("empty_pp_count", int'(count), 1);
    chk("empty_pp_valid", int'(valid_out), 0);
    chk("empty_pp_error", int'(fifo_error), 1);
    pop_exp(10'h3FF);

    // Reset mid-operation with push asserted
    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 10'h050 + 10'(i));
    chk("pre_rst_count", int'(count), 5);
    reset_L = 1'b0;
    cyc(1'b1, 1'b1, 10'h0EE);
    reset_L = 1'b1;
    chk("midrst_count", int'(count), 0);
    chk("midrst_empty", int'(empty), 1);
    chk("midrst_data_out", int'(data_out), 0);
    cyc(1'b0, 1'b1, 10'h0);
    chk("post_rst_pop_valid", int'(valid_out), 0);
    chk("post_rst_pop_count", int'(count), 0);
    chk("post_rst_pop_error", int'(fifo_error), 1);

    cyc(1'b0, 1'b0, 10'h0);
    cyc(1'b0, 1'b0, 10'h0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
